// File: rtl/demux32_1by2_reg_pkg.sv
// Shared constants and types for the registered 32-bit 1-to-2 demultiplexer.
// DEMUX32_STATS_EN (optional) adds per-destination delivery counters.
package demux32_1by2_reg_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned STATS_W     = 16;

  localparam logic SEL_O0 = 1'b0;
  localparam logic SEL_O1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // True when a select value addresses the given destination.
  function automatic logic sel_hit(input logic ctl, input logic sel);
    return ctl == sel;
  endfunction

endpackage

// File: rtl/demux32_1by2_reg_if.sv
// Bus interface for demux32_1by2_reg: one input stream, two output streams.
// Count signals exist only when DEMUX32_STATS_EN is defined.
interface demux32_1by2_reg_if #(
  parameter int unsigned WIDTH = 32
);
  import demux32_1by2_reg_pkg::*;

  logic [WIDTH-1:0] in_data;
  logic             in_ctl;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] O0_data;
  logic             O0_valid;
  logic             O0_ready;

  logic [WIDTH-1:0] O1_data;
  logic             O1_valid;
  logic             O1_ready;

`ifdef DEMUX32_STATS_EN
  logic [STATS_W-1:0] O0_count;
  logic [STATS_W-1:0] O1_count;
`endif

  // Demux side.
  modport slave (
    input  in_data, in_ctl, in_valid, O0_ready, O1_ready,
    output in_ready, O0_data, O0_valid, O1_data, O1_valid
`ifdef DEMUX32_STATS_EN
    , output O0_count, O1_count
`endif
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_ctl, in_valid, O0_ready, O1_ready,
    input  in_ready, O0_data, O0_valid, O1_data, O1_valid
`ifdef DEMUX32_STATS_EN
    , input O0_count, O1_count
`endif
  );

endinterface

// File: rtl/demux32_1by2_reg_slot.sv
// One-entry holding slot for a single demux destination (module demux_slot).
// DEMUX32_STATS_EN adds a wrapping delivery counter.
module demux_slot
  import demux32_1by2_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               can_accept
`ifdef DEMUX32_STATS_EN
  ,
  output logic [STATS_W-1:0] count
`endif
);

  slot_state_t      state;
  logic [WIDTH-1:0] data_q;
  logic             drain;

  assign out_valid  = (state == SLOT_FULL);
  assign out_data   = data_q;
  assign drain      = out_valid & out_ready;
  // A full slot can take a new word in the same cycle it drains.
  assign can_accept = (state == SLOT_EMPTY) | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SLOT_EMPTY;
      data_q <= '0;
    end else if (load) begin
      state  <= SLOT_FULL;
      data_q <= load_data;
    end else if (drain) begin
      state  <= SLOT_EMPTY;
    end
  end

`ifdef DEMUX32_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (drain) begin
      count <= count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux32_1by2_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry holding slot per destination.
// Define DEMUX32_STATS_EN to expose O0_count/O1_count delivery counters.
module demux32_1by2_reg
  import demux32_1by2_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input logic                clk,
  input logic                reset,
  demux32_1by2_reg_if.slave  bus
);

  logic rdy0;
  logic rdy1;
  logic acc;
  logic load0;
  logic load1;

  // Readiness follows only the addressed slot, so a stalled consumer
  // never blocks traffic headed for the other destination.
  assign bus.in_ready = sel_hit(bus.in_ctl, SEL_O1) ? rdy1 : rdy0;
  assign acc          = bus.in_valid & bus.in_ready;
  assign load0        = acc & sel_hit(bus.in_ctl, SEL_O0);
  assign load1        = acc & sel_hit(bus.in_ctl, SEL_O1);

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .load       (load0),
    .load_data  (bus.in_data),
    .out_ready  (bus.O0_ready),
    .out_data   (bus.O0_data),
    .out_valid  (bus.O0_valid),
    .can_accept (rdy0)
`ifdef DEMUX32_STATS_EN
    ,
    .count      (bus.O0_count)
`endif
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .load       (load1),
    .load_data  (bus.in_data),
    .out_ready  (bus.O1_ready),
    .out_data   (bus.O1_data),
    .out_valid  (bus.O1_valid),
    .can_accept (rdy1)
`ifdef DEMUX32_STATS_EN
    ,
    .count      (bus.O1_count)
`endif
  );

endmodule
